ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM, using signed end-relative indices.
// Define ARB_BOUNDS_CHECK_EN to reject indices outside [-RAM_LENGTH, RAM_LENGTH-1].
module ram_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int RAM_LENGTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_idx,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_idx,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  a_gnt,
   output logic                  b_gnt,
   output logic                  a_done,
   output logic                  b_done,
   output logic                  a_err,
   output logic                  b_err,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_d,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);
   typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
   state_t state, state_nxt;

   logic                         any_req;
   logic                         pick_b;
   logic                         take;
   logic                         legal;
   logic                         sel_we;
   logic signed [ADDR_WIDTH-1:0] sel_idx;
   logic [DATA_WIDTH-1:0]        sel_wdata;
   logic                         owner_b;
   logic                         last_b;
   logic                         we_l;
   logic                         bad_l;
   logic [DATA_WIDTH-1:0]        rd;

   // Negative indices count back from the end; wraps modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] to_phys(input logic signed [ADDR_WIDTH-1:0] idx);
      logic [ADDR_WIDTH-1:0] len;
      len = ADDR_WIDTH'(RAM_LENGTH);
      return idx[ADDR_WIDTH-1] ? len + $unsigned(idx) : $unsigned(idx);
   endfunction

`ifdef ARB_BOUNDS_CHECK_EN
   function automatic logic in_range(input logic signed [ADDR_WIDTH-1:0] idx);
      int v;
      v = int'(idx);
      return (v >= -RAM_LENGTH) && (v < RAM_LENGTH);
   endfunction
   assign legal = in_range(sel_idx);
`else
   assign legal = 1'b1;
`endif

   always_comb begin
      any_req   = a_req | b_req;
      pick_b    = (a_req && b_req) ? ~last_b : b_req;
      sel_we    = pick_b ? b_we : a_we;
      sel_idx   = pick_b ? $signed(b_idx) : $signed(a_idx);
      sel_wdata = pick_b ? b_wdata : a_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = GRANT;
         GRANT:   state_nxt = RESP;
         RESP:    state_nxt = any_req ? GRANT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign take = (state_nxt == GRANT) && (state != GRANT);

   // Winner's request is captured on the arbitration edge and presented to the RAM through GRANT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_b  <= 1'b0;
         last_b   <= 1'b1;
         we_l     <= 1'b0;
         bad_l    <= 1'b0;
         ram_addr <= '0;
         ram_d    <= '0;
      end else if (take) begin
         owner_b  <= pick_b;
         last_b   <= pick_b;
         we_l     <= sel_we;
         bad_l    <= ~legal;
         ram_addr <= to_phys(sel_idx);
         ram_d    <= sel_wdata;
      end
   end

   always_comb begin
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      a_done  = 1'b0;
      b_done  = 1'b0;
      a_err   = 1'b0;
      b_err   = 1'b0;
      a_rdata = '0;
      b_rdata = '0;
      ram_we  = (state == GRANT) && we_l && !bad_l;
      rd      = (!we_l && !bad_l) ? ram_q : '0;
      if (state == GRANT) begin
         a_gnt = !owner_b;
         b_gnt = owner_b;
      end
      if (state == RESP) begin
         if (owner_b) begin
            b_done  = 1'b1;
            b_err   = bad_l;
            b_rdata = rd;
         end else begin
            a_done  = 1'b1;
            a_err   = bad_l;
            a_rdata = rd;
         end
      end
   end
endmodule
